// File: rtl/video_timing_pkg.sv
// Shared raster timing constants and helpers for the video pixel path.
// Contents:
//   DEF_*          default timing constants
//   video_timing_t bundle of the nine timing parameters
//   in_window()    true when pos lies in [start, start+len)
package video_timing_pkg;

  localparam int unsigned DEF_CLK_DIV      = 2;
  localparam int unsigned DEF_H_ACTIVE     = 384;
  localparam int unsigned DEF_H_TOTAL      = 512;
  localparam int unsigned DEF_H_SYNC_START = 400;
  localparam int unsigned DEF_H_SYNC_LEN   = 32;
  localparam int unsigned DEF_V_ACTIVE     = 240;
  localparam int unsigned DEF_V_TOTAL      = 262;
  localparam int unsigned DEF_V_SYNC_START = 244;
  localparam int unsigned DEF_V_SYNC_LEN   = 3;

  typedef struct packed {
    int unsigned clk_div;
    int unsigned h_active;
    int unsigned h_total;
    int unsigned h_sync_start;
    int unsigned h_sync_len;
    int unsigned v_active;
    int unsigned v_total;
    int unsigned v_sync_start;
    int unsigned v_sync_len;
  } video_timing_t;

  function automatic logic in_window(input int unsigned pos,
                                     input int unsigned start,
                                     input int unsigned len);
    return (pos >= start) && (pos < start + len);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Pixel-tick divider plus horizontal/vertical raster counters.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   tick           high for the last clock of each pixel period
//   h_cnt, v_cnt   current raster position (advance on tick edges)
//   h_wrap         tick on the last pixel of a line
//   v_wrap         h_wrap on the last line of a frame
module raster_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned H_TOTAL = DEF_H_TOTAL,
  parameter int unsigned V_TOTAL = DEF_V_TOTAL,
  parameter int unsigned V_START = DEF_V_ACTIVE
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic                       tick,
  output logic [$clog2(H_TOTAL)-1:0] h_cnt,
  output logic [$clog2(V_TOTAL)-1:0] v_cnt,
  output logic                       h_wrap,
  output logic                       v_wrap
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  logic [DW-1:0] div_cnt;

  assign tick   = (div_cnt == DW'(CLK_DIV - 1));
  assign h_wrap = tick && (h_cnt == HW'(H_TOTAL - 1));
  assign v_wrap = h_wrap && (v_cnt == VW'(V_TOTAL - 1));

  // Reset lands in vertical blank so the first tick restarts the decoder.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= VW'(V_START);
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) begin
        h_cnt <= h_wrap ? '0 : h_cnt + HW'(1);
        if (h_wrap) begin
          v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/video_pixel_sink.sv
// Consumer end of the display pixel handshake: raster timing, pixel pull,
// sync/DE generation, per-frame decoder restart and sticky underflow flag.
// Ports:
//   clk, reset_n               clock, async active-low reset
//   pixel, pixel_write         pixel index and valid from the decoder
//   pixel_strobe               one-clock consume pulse to the decoder
//   reload_vsr                 one-clock frame restart pulse to the decoder
//   video_index, video_de      registered pixel index and data enable
//   hsync, vsync               active-high syncs
//   underflow, underflow_clr   sticky starvation flag and its clear
module video_pixel_sink
  import video_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
  parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned H_SYNC_LEN   = DEF_H_SYNC_LEN,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
  parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
  parameter int unsigned V_SYNC_LEN   = DEF_V_SYNC_LEN
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pixel,
  input  logic       pixel_write,
  output logic       pixel_strobe,
  output logic       reload_vsr,
  output logic [7:0] video_index,
  output logic       video_de,
  output logic       hsync,
  output logic       vsync,
  output logic       underflow,
  input  logic       underflow_clr
);

  localparam video_timing_t CFG = '{
    clk_div:      CLK_DIV,
    h_active:     H_ACTIVE,
    h_total:      H_TOTAL,
    h_sync_start: H_SYNC_START,
    h_sync_len:   H_SYNC_LEN,
    v_active:     V_ACTIVE,
    v_total:      V_TOTAL,
    v_sync_start: V_SYNC_START,
    v_sync_len:   V_SYNC_LEN
  };

  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  logic          tick;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          unused_wraps;

  raster_counter #(
    .CLK_DIV (CFG.clk_div),
    .H_TOTAL (CFG.h_total),
    .V_TOTAL (CFG.v_total),
    .V_START (CFG.v_active)
  ) u_raster (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .h_wrap  (h_wrap),
    .v_wrap  (v_wrap)
  );

  // Wrap strobes are for other raster consumers; this block keys off counts.
  assign unused_wraps = h_wrap | v_wrap;

  // Per-tick decisions on the pre-increment raster position.
  logic active_c;
  logic take_c;
  logic starve_c;
  logic frame_start_c;

  always_comb begin
    active_c      = (32'(h_cnt) < CFG.h_active) && (32'(v_cnt) < CFG.v_active);
    take_c        = tick && active_c && pixel_write;
    starve_c      = tick && active_c && !pixel_write;
    frame_start_c = tick && (h_cnt == '0) && (32'(v_cnt) == CFG.v_active);
  end

  // Pulses are rewritten every clock so they last exactly one clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_strobe <= 1'b0;
      reload_vsr   <= 1'b0;
    end else begin
      pixel_strobe <= take_c;
      reload_vsr   <= frame_start_c;
    end
  end

  // Video/sync registers hold for a whole pixel period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      video_index <= 8'h00;
      video_de    <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
    end else if (tick) begin
      video_index <= take_c ? pixel : 8'h00;
      video_de    <= active_c;
      hsync       <= in_window(32'(h_cnt), CFG.h_sync_start, CFG.h_sync_len);
      vsync       <= in_window(32'(v_cnt), CFG.v_sync_start, CFG.v_sync_len);
    end
  end

  // Sticky underflow; a new starvation beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow <= 1'b0;
    end else if (starve_c) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_pixel_sink.sv
// Self-checking bench for video_pixel_sink: raster-position model, a
// decoder-like pixel source, and directed literal expectations.
module tb_video_pixel_sink;

  localparam int D   = 2;
  localparam int HA  = 4;
  localparam int HT  = 8;
  localparam int HSS = 5;
  localparam int HSL = 2;
  localparam int VA  = 2;
  localparam int VT  = 4;
  localparam int VSS = 3;
  localparam int VSL = 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pixel;
  logic       pixel_write;
  logic       underflow_clr;
  logic       pixel_strobe;
  logic       reload_vsr;
  logic [7:0] video_index;
  logic       video_de;
  logic       hsync;
  logic       vsync;
  logic       underflow;

  video_pixel_sink #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS),
    .H_SYNC_LEN(HSL), .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS),
    .V_SYNC_LEN(VSL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pixel(pixel), .pixel_write(pixel_write),
    .pixel_strobe(pixel_strobe), .reload_vsr(reload_vsr),
    .video_index(video_index), .video_de(video_de), .hsync(hsync),
    .vsync(vsync), .underflow(underflow), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // k = clock edges since reset release (0 while in reset).
  int k = 0;

  // Source control: 0 ideal, 1 gap after every second pixel, 2 starved.
  int mode = 0;
  int clr_a = -1;
  int clr_b = -1;

  // Source state.
  logic [7:0] next_val = 8'h10;
  int taken = 0;
  int gap = 0;

  // Expected outputs.
  logic [7:0] e_index;
  logic e_de, e_hs, e_vs, e_strobe, e_reload, e_uf;

  // Observation logs.
  int reload_log[$];
  logic [7:0] idx_log[$];
  int strobes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, got, exp);
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, " video_index"}, 32'(video_index), 32'(e_index));
    chk({tag, " video_de"}, 32'(video_de), 32'(e_de));
    chk({tag, " hsync"}, 32'(hsync), 32'(e_hs));
    chk({tag, " vsync"}, 32'(vsync), 32'(e_vs));
    chk({tag, " pixel_strobe"}, 32'(pixel_strobe), 32'(e_strobe));
    chk({tag, " reload_vsr"}, 32'(reload_vsr), 32'(e_reload));
    chk({tag, " underflow"}, 32'(underflow), 32'(e_uf));
  endtask

  // Model + compare + source, all on the falling edge.
  always @(negedge clk) begin
    int n, p, h, v;
    bit act;
    if (!reset_n) begin
      k = 0;
      e_index = 8'h00; e_de = 0; e_hs = 0; e_vs = 0;
      e_strobe = 0; e_reload = 0; e_uf = 0;
      reload_log.delete();
      idx_log.delete();
      strobes = 0;
      cmp_all("reset");
      next_val = 8'h10;
      taken = 0;
      gap = 0;
      pixel = next_val;
      pixel_write = (mode != 2);
      underflow_clr = 1'b0;
    end else begin
      k++;
      if (k % D == 0) begin
        // Raster position from elapsed ticks; reset starts at line VA.
        n = k / D - 1;
        p = n + VA * HT;
        h = p % HT;
        v = (p / HT) % VT;
        act = (h < HA) && (v < VA);
        e_de = act;
        e_strobe = act && (pixel_write === 1'b1);
        e_index = e_strobe ? pixel : 8'h00;
        e_hs = (h >= HSS) && (h < HSS + HSL);
        e_vs = (v >= VSS) && (v < VSS + VSL);
        e_reload = (h == 0) && (v == VA);
        if (act && pixel_write !== 1'b1) e_uf = 1;
        else if (underflow_clr) e_uf = 0;
      end else begin
        e_strobe = 0;
        e_reload = 0;
        if (underflow_clr) e_uf = 0;
      end
      cmp_all("model");
      if (reload_vsr === 1'b1) reload_log.push_back(k);
      if (pixel_strobe === 1'b1) strobes++;
      if (k % D == 0 && video_de === 1'b1) idx_log.push_back(video_index);
      // Decoder-like source reacting to the strobe.
      if (pixel_strobe === 1'b1) begin
        next_val = next_val + 8'h01;
        taken++;
        if (mode == 1 && taken % 2 == 0) gap = 3;
      end else if (gap > 0) begin
        gap--;
      end
      pixel = next_val;
      pixel_write = (mode != 2) && (gap == 0);
      underflow_clr = (k + 1 == clr_a) || (k + 1 == clr_b);
    end
  end

  task automatic wait_k(input int target);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (k != target && guard < 500);
    chk("wait_k reached", 32'(k), 32'(target));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " video_index"}, 32'(video_index), 0);
    chk({tag, " video_de"}, 32'(video_de), 0);
    chk({tag, " hsync"}, 32'(hsync), 0);
    chk({tag, " vsync"}, 32'(vsync), 0);
    chk({tag, " pixel_strobe"}, 32'(pixel_strobe), 0);
    chk({tag, " reload_vsr"}, 32'(reload_vsr), 0);
    chk({tag, " underflow"}, 32'(underflow), 0);
  endtask

  // Asynchronous reset between clock edges, held 3 clocks.
  task automatic do_reset(input int m, input int ca, input int cb);
    #1 reset_n = 1'b0;
    mode = m;
    clr_a = ca;
    clr_b = cb;
    #1 check_zero("async_reset");
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic check_reloads(input string tag);
    chk({tag, " reload count"}, 32'(reload_log.size()), 2);
    chk({tag, " reload first"}, (reload_log.size() > 0) ? 32'(reload_log[0]) : 32'hffff, 2);
    chk({tag, " reload second"}, (reload_log.size() > 1) ? 32'(reload_log[1]) : 32'hffff, 66);
  endtask

  logic [7:0] exp_idx[8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

  initial begin
    // Reset release with ideal source; sync shape literals along the way.
    mode = 0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    wait_k(1);  check_zero("s1_k1");
    wait_k(2);  chk("s1 reload k2", 32'(reload_vsr), 1);
                chk("s1 de k2", 32'(video_de), 0);
    wait_k(3);  chk("s1 reload k3", 32'(reload_vsr), 0);
    wait_k(17); chk("s4 vsync k17", 32'(vsync), 0);
    wait_k(18); chk("s4 vsync k18", 32'(vsync), 1);
    wait_k(33); chk("s4 vsync k33", 32'(vsync), 1);
                chk("s4 de k33", 32'(video_de), 0);
    wait_k(34); chk("s4 vsync k34", 32'(vsync), 0);
                chk("s4 de k34", 32'(video_de), 1);
                chk("s2 index k34", 32'(video_index), 32'h10);
    wait_k(41); chk("s4 de k41", 32'(video_de), 1);
    wait_k(42); chk("s4 de k42", 32'(video_de), 0);
    wait_k(43); chk("s4 hsync k43", 32'(hsync), 0);
    wait_k(44); chk("s4 hsync k44", 32'(hsync), 1);
    wait_k(47); chk("s4 hsync k47", 32'(hsync), 1);
    wait_k(48); chk("s4 hsync k48", 32'(hsync), 0);
    wait_k(60);
    chk("s2 strobes per frame", 32'(strobes), 8);
    chk("s2 underflow", 32'(underflow), 0);
    chk("s2 index count", 32'(idx_log.size()), 8);
    for (int i = 0; i < 8; i++)
      chk("s2 index seq", (i < idx_log.size()) ? 32'(idx_log[i]) : 32'hffff, 32'(exp_idx[i]));
    wait_k(70);
    check_reloads("s1");

    // Decoder-style source with refill gaps.
    do_reset(1, -1, -1);
    wait_k(36); chk("s3 index k36", 32'(video_index), 32'h11);
                chk("s3 underflow k36", 32'(underflow), 0);
    wait_k(38); chk("s3 underflow k38", 32'(underflow), 1);
                chk("s3 de k38", 32'(video_de), 1);
                chk("s3 index k38", 32'(video_index), 0);
    wait_k(40); chk("s3 index k40", 32'(video_index), 32'h12);
    wait_k(50); chk("s3 index k50", 32'(video_index), 32'h13);
    wait_k(52); chk("s3 index k52", 32'(video_index), 0);
    wait_k(54); chk("s3 index k54", 32'(video_index), 32'h14);

    // Clear colliding with a new underflow, then clear alone.
    do_reset(2, 34, 37);
    wait_k(33); chk("s5 underflow k33", 32'(underflow), 0);
    mode = 0;
    wait_k(34); chk("s5 set beats clr", 32'(underflow), 1);
    wait_k(36); chk("s5 held k36", 32'(underflow), 1);
    wait_k(37); chk("s5 clr alone", 32'(underflow), 0);

    // Reset in the middle of active line 1, then a clean restart.
    wait_k(52);
    chk("s6 de before reset", 32'(video_de), 1);
    do_reset(0, -1, -1);
    wait_k(1);  check_zero("s6_k1");
    wait_k(2);  chk("s6 reload k2", 32'(reload_vsr), 1);
    wait_k(70);
    check_reloads("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

endmodule
